// File: rtl/ks_sub_seq_pkg.sv
// Shared definitions for the sequential Kogge-Stone subtractor: chunk width,
// FSM encoding, counter sizing and the prefix carry operator cells.
`default_nettype none

package ks_sub_seq_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the chunk counter, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic prefix_g(input logic gh, input logic ph, input logic gl);
    return gh | (ph & gl);
  endfunction

  function automatic logic prefix_p(input logic ph, input logic pl);
    return ph & pl;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ks_sub16_slice.sv
// Combinational 16-bit Kogge-Stone slice computing x + ~y + c.
`default_nettype none

module ks_sub16_slice
  import ks_sub_seq_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        c,
  output logic [15:0] s,
  output logic        co
);

  logic [15:0]      p;
  logic [15:0]      g;
  logic [15:0]      carry;
  logic [4:0][15:0] gl;
  logic [4:0][15:0] pl;

  assign p = x ^ ~y;
  assign g = x & ~y;

  // Carry-in is folded into bit 0, so bit 0 has nothing further to propagate.
  assign gl[0] = {g[15:1], g[0] | (p[0] & c)};
  assign pl[0] = {p[15:1], 1'b0};

  genvar lv, i;
  generate
    for (lv = 0; lv < 4; lv++) begin : g_level
      localparam int D = 1 << lv;
      for (i = 0; i < 16; i++) begin : g_bit
        if (i >= D) begin : g_cell
          assign gl[lv+1][i] = prefix_g(gl[lv][i], pl[lv][i], gl[lv][i-D]);
          assign pl[lv+1][i] = prefix_p(pl[lv][i], pl[lv][i-D]);
        end else begin : g_pass
          assign gl[lv+1][i] = gl[lv][i];
          assign pl[lv+1][i] = pl[lv][i];
        end
      end
    end
  endgenerate

  assign carry = {gl[4][14:0], c};
  assign s     = p ^ carry;
  assign co    = g[15] | (p[15] & carry[15]);

endmodule

`default_nettype wire

// File: rtl/ks_sub_seq.sv
// Handshaked multi-cycle wide subtractor: one 16-bit chunk per cycle, LSB first,
// borrow chained through a carry register; reports borrow, zero and less-than.
`default_nettype none

module ks_sub_seq
  import ks_sub_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*WORDS-1:0]    a,
  input  logic [16*WORDS-1:0]    b,
  input  logic                   bin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*WORDS-1:0]    diff,
  output logic                   bout,
  output logic                   zero,
  output logic                   lt
);

  localparam int            W      = CHUNK_W * WORDS;
  localparam int            KW     = clog2(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [KW-1:0]        k;
  logic                 carry;
  logic [W-1:0]         a_r;
  logic [W-1:0]         b_r;
  logic [W-1:0]         diff_r;
  logic [W-1:0]         diff_nxt;
  logic                 bout_r;
  logic                 zero_r;
  logic [CHUNK_W-1:0]   x_k;
  logic [CHUNK_W-1:0]   y_k;
  logic [CHUNK_W-1:0]   sum;
  logic                 co;
  logic                 last;

  assign last = (k == K_LAST);

  always_comb begin
    x_k = a_r[CHUNK_W*k +: CHUNK_W];
    y_k = b_r[CHUNK_W*k +: CHUNK_W];
  end

  ks_sub16_slice u_slice (
    .x  (x_k),
    .y  (y_k),
    .c  (carry),
    .s  (sum),
    .co (co)
  );

  // Complete diff including the chunk produced this cycle, so zero sees the final value.
  always_comb begin
    diff_nxt = diff_r;
    diff_nxt[CHUNK_W*k +: CHUNK_W] = sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k      <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= ~bin;
            k     <= '0;
          end
        end
        RUN: begin
          diff_r <= diff_nxt;
          carry  <= co;
          k      <= k + 1'b1;
          if (last) begin
            bout_r <= ~co;
            zero_r <= (diff_nxt == '0);
            k      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_r;
  assign bout = bout_r;
  assign lt   = bout_r;
  assign zero = zero_r;

endmodule

`default_nettype wire
